// File: rtl/seg7_scan_out.sv
// seg7_scan_out
// Bus-programmed driver for a 4-digit multiplexed 7-segment display.
// The CPU writes the digit data, control and brightness registers over a
// simple cs/we/addr peripheral bus. The block then scans the four digit
// commons in turn. Each digit slot starts with a dark guard interval, which
// suppresses ghosting. A brightness-dependent lit window follows.
//
// The displayed digits come from a shadow copy of DATA. The shadow copy is
// refreshed only at a frame boundary, so the digits never tear mid-frame.
//
// Ports:
//   clk    system clock
//   rst    synchronous active-high reset
//   cs     peripheral select
//   we     1 = write, 0 = read (qualified by cs)
//   addr   register select: 0 DATA, 1 CTRL, 2 BRIGHT, 3 STATUS (read-only)
//   wrdat  write data
//   rddat  combinational read data, 0 unless cs && !we
//   seg    registered segments {dp,g,f,e,d,c,b,a}
//   com    registered digit commons, com[0] = rightmost digit
//   frame  one-cycle pulse after each frame boundary
module seg7_scan_out #(
    parameter int SCAN_DIV       = 12500,
    parameter int GUARD          = 64,
    parameter bit COM_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [15:0] wrdat,
    output logic [15:0] rddat,
    output logic [7:0]  seg,
    output logic [3:0]  com,
    output logic        frame
);

    localparam int             PW        = $clog2(SCAN_DIV);
    localparam int             STEP      = (SCAN_DIV - GUARD) / 16;
    localparam logic [PW-1:0]  PCNT_LAST = PW'(SCAN_DIV - 1);
    localparam logic [7:0]     SEG_OFF   = {8{SEG_ACTIVE_LOW}};
    localparam logic [3:0]     COM_OFF   = {4{COM_ACTIVE_LOW}};

    logic [15:0]   data_reg;
    logic [15:0]   shadow;
    logic          enable;
    logic [3:0]    dp;
    logic [3:0]    blank;
    logic [3:0]    bright;
    logic          pending;
    logic [PW-1:0] pcnt;
    logic [1:0]    dig;

    logic          wr_data;
    logic          wr_ctrl;
    logic          wr_bright;
    logic          boundary;
    logic          start;
    logic          lit;
    logic [31:0]   pcnt_ext;
    logic [31:0]   win_end;
    logic [3:0]    nibble;
    logic [6:0]    hex_seg;
    logic [7:0]    seg_on;
    logic [3:0]    com_on;

    always_comb begin
        wr_data   = cs && we && (addr == 2'd0);
        wr_ctrl   = cs && we && (addr == 2'd1);
        wr_bright = cs && we && (addr == 2'd2);
        boundary  = enable && (pcnt == PCNT_LAST) && (dig == 2'd3);
        // A 0->1 write of the enable bit restarts the scan with fresh data.
        start     = wr_ctrl && !enable && wrdat[0];
    end

    always_comb begin
        rddat = 16'h0000;
        if (cs && !we) begin
            case (addr)
                2'd0: rddat = data_reg;
                2'd1: rddat = {4'h0, blank, dp, 3'b000, enable};
                2'd2: rddat = {12'h000, bright};
                default: rddat = {13'h0000, pending, dig};
            endcase
        end
    end

    // The lit window runs after the guard interval. Its length is
    // (bright+1) brightness steps, which gives 16 brightness levels.
    always_comb begin
        pcnt_ext = 32'(pcnt);
        win_end  = 32'(GUARD) + (32'(bright) + 32'd1) * 32'(STEP);
        lit      = enable && !blank[dig] &&
                   (pcnt_ext >= 32'(GUARD)) && (pcnt_ext < win_end);
        nibble   = shadow[{dig, 2'b00} +: 4];
    end

    always_comb begin
        hex_seg = 7'h00;
        case (nibble)
            4'h0: hex_seg = 7'h3F;
            4'h1: hex_seg = 7'h06;
            4'h2: hex_seg = 7'h5B;
            4'h3: hex_seg = 7'h4F;
            4'h4: hex_seg = 7'h66;
            4'h5: hex_seg = 7'h6D;
            4'h6: hex_seg = 7'h7D;
            4'h7: hex_seg = 7'h07;
            4'h8: hex_seg = 7'h7F;
            4'h9: hex_seg = 7'h6F;
            4'hA: hex_seg = 7'h77;
            4'hB: hex_seg = 7'h7C;
            4'hC: hex_seg = 7'h39;
            4'hD: hex_seg = 7'h5E;
            4'hE: hex_seg = 7'h79;
            default: hex_seg = 7'h71;
        endcase
        seg_on = {dp[dig], hex_seg};
        com_on = 4'b0001 << dig;
    end

    // Register file and shadow/pending handling. A DATA write that lands
    // exactly on the boundary cycle goes straight into the shadow register,
    // so the pending flag is not left set.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg <= 16'h0000;
            shadow   <= 16'h0000;
            enable   <= 1'b0;
            dp       <= 4'h0;
            blank    <= 4'h0;
            bright   <= 4'hF;
            pending  <= 1'b0;
        end else begin
            if (wr_data) begin
                data_reg <= wrdat;
            end
            if (wr_ctrl) begin
                enable <= wrdat[0];
                dp     <= wrdat[7:4];
                blank  <= wrdat[11:8];
            end
            if (wr_bright) begin
                bright <= wrdat[3:0];
            end

            if (start) begin
                shadow  <= data_reg;
                pending <= 1'b0;
            end else if (boundary) begin
                shadow  <= wr_data ? wrdat : data_reg;
                pending <= 1'b0;
            end else if (wr_data) begin
                pending <= 1'b1;
            end
        end
    end

    // Slot and digit counters. They are parked at zero while disabled.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            pcnt <= '0;
            dig  <= 2'd0;
        end else if (pcnt == PCNT_LAST) begin
            pcnt <= '0;
            dig  <= dig + 2'd1;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    // The output registers follow the counter state by one cycle. The
    // polarity is applied by XOR with the inactive pattern.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg   <= SEG_OFF;
            com   <= COM_OFF;
            frame <= 1'b0;
        end else begin
            seg   <= lit ? (seg_on ^ SEG_OFF) : SEG_OFF;
            com   <= lit ? (com_on ^ COM_OFF) : COM_OFF;
            frame <= boundary;
        end
    end

endmodule

// File: tb/tb_seg7_scan_out.sv
// Testbench for seg7_scan_out, built with SCAN_DIV=68 and GUARD=4, so STEP is
// 4 and a frame lasts 272 cycles.
// A time-based reference model predicts seg/com/frame every cycle. The model
// derives the slot position from the cycle count since scanning started.
// Register reads are predicted by the same model. Directed sequences pin
// down the exact slot timing with constants.
module tb_seg7_scan_out;

    localparam int SD    = 68;
    localparam int GD    = 4;
    localparam int FRAME = 4 * SD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [15:0] wrdat = 16'h0000;
    logic [15:0] rddat;
    logic [7:0]  seg;
    logic [3:0]  com;
    logic        frame;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit chk_en = 1'b0;

    seg7_scan_out #(
        .SCAN_DIV(SD),
        .GUARD(GD),
        .COM_ACTIVE_LOW(1'b1),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cs(cs),
        .we(we),
        .addr(addr),
        .wrdat(wrdat),
        .rddat(rddat),
        .seg(seg),
        .com(com),
        .frame(frame)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [15:0] m_data = 0, m_shadow = 0;
    logic        m_en = 0, m_pend = 0;
    logic [3:0]  m_dp = 0, m_blank = 0, m_bright = 4'hF;
    int          m_t = 0;
    logic [7:0]  e_seg = 8'hFF;
    logic [3:0]  e_com = 4'hF;
    logic        e_frame = 0;

    function automatic logic [15:0] model_read(input logic [1:0] a);
        case (a)
            2'd0: return m_data;
            2'd1: return {4'h0, m_blank, m_dp, 3'b000, m_en};
            2'd2: return {12'h000, m_bright};
            default: return {13'h0, m_pend, 2'((m_t / SD) % 4)};
        endcase
    endfunction

    // The model advances a frame-position counter m_t (0..271) while enabled.
    // The digit and in-slot position come from division and modulo.
    always @(posedge clk) begin
        int  pc, dg;
        bit  bnd, lit, old_en;
        logic [7:0] s;
        if (rst) begin
            m_data = 0; m_shadow = 0; m_en = 0; m_pend = 0;
            m_dp = 0; m_blank = 0; m_bright = 4'hF; m_t = 0;
            e_seg = 8'hFF; e_com = 4'hF; e_frame = 0;
        end else begin
            pc  = m_t % SD;
            dg  = (m_t / SD) % 4;
            bnd = m_en && (m_t == FRAME - 1);
            lit = m_en && !m_blank[dg] && pc >= GD && pc < GD + (int'(m_bright) + 1) * ((SD - GD) / 16);
            if (lit) begin
                s     = {m_dp[dg], hex_tab[m_shadow[dg*4 +: 4]]};
                e_seg = ~s;
                e_com = ~(4'b0001 << dg);
            end else begin
                e_seg = 8'hFF;
                e_com = 4'hF;
            end
            e_frame = bnd;
            old_en  = m_en;
            if (bnd) begin
                m_shadow = m_data;
                m_pend   = 0;
            end
            if (cs && we) begin
                case (addr)
                    2'd0: begin
                        m_data = wrdat;
                        if (bnd) m_shadow = wrdat;
                        else     m_pend = 1;
                    end
                    2'd1: begin
                        if (!m_en && wrdat[0]) begin
                            m_shadow = m_data;
                            m_pend   = 0;
                        end
                        m_en    = wrdat[0];
                        m_dp    = wrdat[7:4];
                        m_blank = wrdat[11:8];
                    end
                    2'd2: m_bright = wrdat[3:0];
                    default: ;
                endcase
            end
            m_t = old_en ? (m_t + 1) % FRAME : 0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Compare the outputs with the model on every cycle.
    always @(negedge clk) begin
        if (chk_en) checkOutput("scan model", {19'h0, seg, com, frame}, {19'h0, e_seg, e_com, e_frame});
    end

    task automatic applyStimulus(input logic c, input logic w, input logic [1:0] a, input logic [15:0] d);
        cs = c; we = w; addr = a; wrdat = d;
    endtask

    task automatic busWrite(input logic [1:0] a, input logic [15:0] d);
        applyStimulus(1, 1, a, d);
        @(negedge clk);
        applyStimulus(0, 0, 2'd0, 16'h0);
    endtask

    task automatic busRead(input logic [1:0] a, output logic [15:0] d);
        applyStimulus(1, 0, a, 16'h0);
        #1;
        d = rddat;
        applyStimulus(0, 0, 2'd0, 16'h0);
    endtask

    task automatic skip(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitFrame(output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!frame && waited < 2 * FRAME + 50);
        if (!frame) checkOutput("frame timeout", 0, 1);
    endtask

    typedef struct {
        bit          wr;
        logic        c;
        logic        w;
        logic [1:0]  a;
        logic [15:0] d;
        logic [15:0] exp;
    } reg_vec_t;

    initial begin
        reg_vec_t    vecs [11];
        logic [15:0] rd;
        int          waited;
        bit          frame_seen;

        vecs[0]  = '{0, 1, 0, 2'd2, 16'h0000, 16'h000F};
        vecs[1]  = '{1, 1, 0, 2'd1, 16'hFFF0, 16'h0FF0};
        vecs[2]  = '{1, 1, 0, 2'd2, 16'hFFF7, 16'h0007};
        vecs[3]  = '{1, 1, 0, 2'd3, 16'hFFFF, 16'h0000};
        vecs[4]  = '{1, 1, 0, 2'd0, 16'hBEEF, 16'hBEEF};
        vecs[5]  = '{0, 1, 0, 2'd3, 16'h0000, 16'h0004};
        vecs[6]  = '{0, 0, 0, 2'd0, 16'h0000, 16'h0000};
        vecs[7]  = '{0, 0, 0, 2'd3, 16'h0000, 16'h0000};
        vecs[8]  = '{0, 1, 1, 2'd0, 16'h1111, 16'h0000};
        vecs[9]  = '{1, 1, 0, 2'd1, 16'h0000, 16'h0000};
        vecs[10] = '{1, 1, 0, 2'd2, 16'h000F, 16'h000F};

        skip(3);
        rst = 0;
        chk_en = 1;
        checkOutput("reset seg", 32'(seg), 32'hFF);
        checkOutput("reset com", 32'(com), 32'hF);
        checkOutput("reset frame", 32'(frame), 32'h0);

        frame_seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (frame) frame_seen = 1;
        end
        checkOutput("idle frame", 32'(frame_seen), 32'h0);
        checkOutput("idle seg/com", {20'h0, seg, com}, {20'h0, 8'hFF, 4'hF});

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].wr) busWrite(vecs[i].a, vecs[i].d);
            applyStimulus(vecs[i].c, vecs[i].w, vecs[i].a, vecs[i].d);
            #1;
            checkOutput($sformatf("reg vec %0d", i), 32'(rddat), 32'(vecs[i].exp));
            applyStimulus(0, 0, 2'd0, 16'h0);
            @(negedge clk);
        end

        // Basic scanning with DATA=1234 at full brightness
        busWrite(2'd0, 16'h1234);
        busWrite(2'd1, 16'h0001);
        waitFrame(waited);
        checkOutput("first frame delay", 32'(waited), 32'(FRAME));
        skip(4);
        checkOutput("guard dark", {20'h0, seg, com}, {20'h0, 8'hFF, 4'hF});
        skip(1);
        checkOutput("d0 first lit", {20'h0, seg, com}, {20'h0, 8'h99, 4'hE});
        skip(63);
        checkOutput("d0 last lit", {20'h0, seg, com}, {20'h0, 8'h99, 4'hE});
        skip(1);
        checkOutput("d1 guard", {20'h0, seg, com}, {20'h0, 8'hFF, 4'hF});
        skip(140);
        checkOutput("d3 lit", {20'h0, seg, com}, {20'h0, 8'hF9, 4'h7});
        waitFrame(waited);
        checkOutput("frame period", 32'(waited), 32'd63);

        // Brightness 3: lit for pcnt 4..19
        busWrite(2'd2, 16'h0003);
        skip(4);
        checkOutput("bright3 start", {20'h0, seg, com}, {20'h0, 8'h99, 4'hE});
        skip(15);
        checkOutput("bright3 end", {20'h0, seg, com}, {20'h0, 8'h99, 4'hE});
        skip(1);
        checkOutput("bright3 dark", {20'h0, seg, com}, {20'h0, 8'hFF, 4'hF});
        busWrite(2'd1, 16'h0201);
        skip(51);
        checkOutput("d1 blanked", {20'h0, seg, com}, {20'h0, 8'hFF, 4'hF});
        skip(68);
        checkOutput("d2 lit", {20'h0, seg, com}, {20'h0, 8'hA4, 4'hB});
        busWrite(2'd1, 16'h0011);
        waitFrame(waited);
        skip(5);
        checkOutput("d0 with dp", {20'h0, seg, com}, {20'h0, 8'h19, 4'hE});
        busWrite(2'd2, 16'h000F);
        busWrite(2'd1, 16'h0001);

        // Mid-frame DATA write stays hidden until the boundary
        busWrite(2'd0, 16'hABCD);
        busRead(2'd3, rd);
        checkOutput("pending set", 32'(rd), 32'h0004);
        skip(65);
        checkOutput("old data shown", {20'h0, seg, com}, {20'h0, 8'hB0, 4'hD});
        waitFrame(waited);
        busRead(2'd3, rd);
        checkOutput("pending cleared", 32'(rd), 32'h0000);
        skip(5);
        checkOutput("new data shown", {20'h0, seg, com}, {20'h0, 8'hA1, 4'hE});

        // DATA write exactly on the boundary cycle
        skip(266);
        applyStimulus(1, 1, 2'd0, 16'hFFFF);
        @(negedge clk);
        applyStimulus(0, 0, 2'd0, 16'h0);
        checkOutput("boundary frame", 32'(frame), 32'h1);
        busRead(2'd3, rd);
        checkOutput("boundary pending", 32'(rd), 32'h0000);
        busRead(2'd0, rd);
        checkOutput("boundary data", 32'(rd), 32'hFFFF);
        skip(5);
        checkOutput("F on d0", {20'h0, seg, com}, {20'h0, 8'h8E, 4'hE});
        skip(136);
        checkOutput("F on d2", {20'h0, seg, com}, {20'h0, 8'h8E, 4'hB});

        // Reset in the middle of the digit 2 slot
        rst = 1;
        @(negedge clk);
        rst = 0;
        checkOutput("rst outputs", {19'h0, seg, com, frame}, {19'h0, 8'hFF, 4'hF, 1'b0});
        busRead(2'd0, rd);
        checkOutput("rst data", 32'(rd), 32'h0000);
        busRead(2'd1, rd);
        checkOutput("rst ctrl", 32'(rd), 32'h0000);
        busRead(2'd2, rd);
        checkOutput("rst bright", 32'(rd), 32'h000F);

        // Randomized bus traffic checked against the model
        busWrite(2'd0, 16'($urandom));
        busWrite(2'd1, 16'h0001);
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [1:0]  a;
            logic [15:0] d;
            r = $urandom_range(0, 199);
            a = 2'($urandom_range(0, 3));
            d = 16'($urandom);
            if (a == 2'd1 && $urandom_range(0, 9) != 0) d[0] = 1'b1;
            if (r < 10) begin
                applyStimulus(1, 1, a, d);
            end else if (r < 30) begin
                applyStimulus(1, 0, a, 16'h0);
                #1;
                checkOutput("random read", 32'(rddat), 32'(model_read(a)));
            end else if (r == 199) begin
                applyStimulus(0, 0, 2'd0, 16'h0);
                rst = 1;
            end else begin
                applyStimulus(0, 0, 2'd0, 16'h0);
            end
            @(negedge clk);
            rst = 0;
        end
        applyStimulus(0, 0, 2'd0, 16'h0);
        skip(2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
